// File: rtl/jts16_obj_dbuf.sv
// Double-buffered object table RAM: CPU side and scanner side see separate buffers,
// published on swap either by flipping roles (MODE 0) or by a copy/clear engine (MODE 1).
module jts16_obj_dbuf #(
   parameter int          AW     = 10,
   parameter int          MODE   = 0,
   parameter int          CLR    = 0,
   parameter logic [15:0] CLRVAL = 16'h0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          obj_cs,
   input  logic [AW-1:0] cpu_addr,
   input  logic [15:0]   cpu_dout,
   input  logic [1:0]    dsn,
   output logic [15:0]   cpu_din,
   input  logic [AW-1:0] tbl_addr,
   output logic [15:0]   tbl_dout,
   input  logic          tbl_we,
   input  logic [15:0]   tbl_din,
   input  logic          swap,
   output logic          busy,
   output logic          bank,
   output logic          done
);

   localparam int N = 1 << AW;

   typedef enum logic [1:0] {IDLE, COPY, CLEAR} state_t;

   state_t        state, state_nx;
   logic [AW:0]   cnt;
   logic          pending;
   logic [1:0]    cpu_be;
   logic          eng_rd, clr_wr, copy_end, clr_end;
   logic          eng_vld_p1;
   logic [AW-1:0] eng_wa_p1;
   logic [15:0]   eng_q_p1;

   logic [15:0]   ram0 [N];
   logic [15:0]   ram1 [N];

   assign cpu_be   = ~dsn & {2{obj_cs}};
   assign copy_end = (state == COPY) && cnt[AW];
   assign clr_end  = (state == CLEAR) && (&cnt[AW-1:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (MODE != 0 && (swap || pending)) state_nx = COPY;
         COPY:    if (cnt[AW]) state_nx = (CLR != 0) ? CLEAR : IDLE;
         CLEAR:   if (&cnt[AW-1:0]) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // A CPU write to the address being cleared suppresses the clear write
   always_comb begin
      busy   = (state != IDLE);
      eng_rd = (state == COPY) && !cnt[AW];
      clr_wr = (state == CLEAR) && !((|cpu_be) && (cpu_addr == cnt[AW-1:0]));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         pending    <= 1'b0;
         done       <= 1'b0;
         bank       <= 1'b0;
         eng_vld_p1 <= 1'b0;
      end else begin
         if (state != state_nx)  cnt <= '0;
         else if (state != IDLE) cnt <= cnt + 1'b1;
         if (state == IDLE) pending <= 1'b0;
         else if (swap)     pending <= 1'b1;
         if (MODE == 0) done <= swap;
         else           done <= (copy_end && CLR == 0) || clr_end;
         if (MODE == 0 && swap) bank <= ~bank;
         eng_vld_p1 <= eng_rd;
      end
   end

   // Read stage: registered outputs; engine read feeds the write one cycle later
   always_ff @(posedge clk) begin
      cpu_din   <= bank ? ram1[cpu_addr] : ram0[cpu_addr];
      tbl_dout  <= bank ? ram0[tbl_addr] : ram1[tbl_addr];
      eng_q_p1  <= bank ? ram1[cnt[AW-1:0]] : ram0[cnt[AW-1:0]];
      eng_wa_p1 <= cnt[AW-1:0];
   end

   // Later assignments take priority: CPU over clear, engine over scanner
   always_ff @(posedge clk) begin
      if (!bank) begin
         if (clr_wr)    ram0[cnt[AW-1:0]] <= CLRVAL;
         if (cpu_be[1]) ram0[cpu_addr][15:8] <= cpu_dout[15:8];
         if (cpu_be[0]) ram0[cpu_addr][7:0]  <= cpu_dout[7:0];
      end else begin
         if (tbl_we)     ram0[tbl_addr]  <= tbl_din;
         if (eng_vld_p1) ram0[eng_wa_p1] <= eng_q_p1;
      end
   end

   always_ff @(posedge clk) begin
      if (bank) begin
         if (clr_wr)    ram1[cnt[AW-1:0]] <= CLRVAL;
         if (cpu_be[1]) ram1[cpu_addr][15:8] <= cpu_dout[15:8];
         if (cpu_be[0]) ram1[cpu_addr][7:0]  <= cpu_dout[7:0];
      end else begin
         if (tbl_we)     ram1[tbl_addr]  <= tbl_din;
         if (eng_vld_p1) ram1[eng_wa_p1] <= eng_q_p1;
      end
   end

endmodule
